// File: rtl/sorted_insert.sv
// sorted_insert: writer side of a sorted-array RAM. Each accepted key is
// inserted into a single-port synchronous RAM so that entries [0..Count-1]
// stay in ascending unsigned order. Larger entries are moved up one slot
// (an insertion-sort step), and the key is then written into the gap.
module sorted_insert #(
  parameter int SIZE = 32,
  parameter int AW   = 5,
  parameter int DW   = 8
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic [DW-1:0] a,
  input  logic          Start,
  input  logic          Clear,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic [AW-1:0] Loc,
  output logic [AW:0]   Count,
  output logic          Full,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CMP   = 3'd2,
    SHIFT = 3'd3,
    PLACE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [AW:0] LP_SIZE = (AW+1)'(SIZE);

  state_t        r_state;
  logic [DW-1:0] r_a_q;    // key being inserted
  logic [AW:0]   r_j;      // slot that is currently free (write index)
  logic [DW-1:0] r_d_q;    // entry read back, moved up during SHIFT
  logic [AW-1:0] r_loc;
  logic [AW:0]   r_count;
  logic          r_full;

  // j-1 is the neighbour below the free slot; it is the next entry to test.
  logic [AW:0]   w_jm1;
  assign w_jm1 = r_j - 1'b1;

  // Control FSM and datapath registers. The scan walks down from the top of
  // the valid region; each entry strictly larger than the key moves up one
  // slot. Equal entries stop the scan, so duplicates land after their equals.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_a_q   <= '0;
      r_j     <= '0;
      r_d_q   <= '0;
      r_loc   <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (Clear) begin
            // Clear wins over a simultaneous Start; RAM contents are left as-is.
            r_count <= '0;
          end else if (Start) begin
            if (r_count == LP_SIZE) begin
              r_full  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_a_q  <= a;
              r_full <= 1'b0;
              r_j    <= r_count;
              // An empty array needs no scan: write straight to slot 0.
              r_state <= (r_count == '0) ? PLACE : READ;
            end
          end
        end
        READ: begin
          r_state <= CMP;
        end
        CMP: begin
          r_d_q   <= mem_rdata;
          r_state <= (mem_rdata > r_a_q) ? SHIFT : PLACE;
        end
        SHIFT: begin
          r_j     <= w_jm1;
          r_state <= (w_jm1 == '0) ? PLACE : READ;
        end
        PLACE: begin
          r_loc   <= r_j[AW-1:0];
          r_count <= r_count + 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // RAM port decode: purely from state and registers so mem_we falls as soon
  // as reset asserts, and nothing ever depends combinationally on mem_rdata.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (r_state)
      READ, CMP: begin
        mem_addr = w_jm1[AW-1:0];
      end
      SHIFT: begin
        mem_addr  = r_j[AW-1:0];
        mem_wdata = r_d_q;
        mem_we    = 1'b1;
      end
      PLACE: begin
        mem_addr  = r_j[AW-1:0];
        mem_wdata = r_a_q;
        mem_we    = 1'b1;
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  assign Loc   = r_loc;
  assign Count = r_count;
  assign Full  = r_full;
  assign Busy  = (r_state != IDLE);
  assign Done  = (r_state == DONE);

endmodule

// File: tb/tb_sorted_insert.sv
// Directed bench for sorted_insert with a 1-cycle-latency synchronous RAM model.
module tb_sorted_insert;

  localparam int SIZE = 32;
  localparam int AW   = 5;
  localparam int DW   = 8;

  logic          CLOCK_50 = 1'b0;
  logic          reset_n  = 1'b0;
  logic [DW-1:0] a        = '0;
  logic          Start    = 1'b0;
  logic          Clear    = 1'b0;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [AW-1:0] Loc;
  logic [AW:0]   Count;
  logic          Full;
  logic          Busy;
  logic          Done;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  logic [DW-1:0] ram [SIZE];

  sorted_insert #(.SIZE(SIZE), .AW(AW), .DW(DW)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .a        (a),
    .Start    (Start),
    .Clear    (Clear),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .Loc      (Loc),
    .Count    (Count),
    .Full     (Full),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous RAM, read data one cycle after the address.
  always @(posedge CLOCK_50) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge CLOCK_50) begin
    if (mem_we) we_cnt++;
    if (Done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses Start for one cycle; lat = cycles from the Start cycle to Done.
  task automatic do_insert(input logic [DW-1:0] key, output int lat);
    @(negedge CLOCK_50);
    a = key; Start = 1'b1;
    @(negedge CLOCK_50);
    Start = 1'b0;
    lat = 1;
    while (!Done && lat < 200) begin
      @(negedge CLOCK_50);
      lat++;
    end
    if (!Done) chk("done_timeout", 32'(lat), 32'd0);
  endtask

  task automatic do_clear();
    @(negedge CLOCK_50);
    Clear = 1'b1;
    @(negedge CLOCK_50);
    Clear = 1'b0;
  endtask

  initial begin
    int lat, we0, d0, pos, s, t, exp_lat, lo, hi, mid, found;
    int q[$];
    logic [DW-1:0] key;

    // Reset state
    #12;
    chk("rst_count", 32'(Count), 0);
    chk("rst_loc", 32'(Loc), 0);
    chk("rst_full", 32'(Full), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;

    // Test 1: first insert into an empty array
    do_insert(8'h40, lat);
    chk("t1_lat", 32'(lat), 2);
    chk("t1_loc", 32'(Loc), 0);
    chk("t1_count", 32'(Count), 1);
    chk("t1_ram0", 32'(ram[0]), 32'h40);

    // Test 2: front, back and duplicate inserts
    do_insert(8'h10, lat);
    chk("t2a_loc", 32'(Loc), 0);
    chk("t2a_lat", 32'(lat), 5);
    do_insert(8'h80, lat);
    chk("t2b_loc", 32'(Loc), 2);
    chk("t2b_lat", 32'(lat), 4);
    do_insert(8'h40, lat);
    chk("t2c_loc", 32'(Loc), 2);
    chk("t2c_lat", 32'(lat), 7);
    chk("t2_count", 32'(Count), 4);
    chk("t2_ram0", 32'(ram[0]), 32'h10);
    chk("t2_ram1", 32'(ram[1]), 32'h40);
    chk("t2_ram2", 32'(ram[2]), 32'h40);
    chk("t2_ram3", 32'(ram[3]), 32'h80);

    // Test 3: 31 ascending keys, then a minimum that shifts all of them
    do_clear();
    chk("t3_clear_count", 32'(Count), 0);
    for (int i = 0; i < 31; i++) begin
      do_insert(8'(i*4 + 4), lat);
      chk("t3_asc_lat", 32'(lat), (i == 0) ? 2 : 4);
    end
    do_insert(8'h00, lat);
    chk("t3_min_lat", 32'(lat), 95);
    chk("t3_min_loc", 32'(Loc), 0);
    chk("t3_count", 32'(Count), 32);
    chk("t3_ram0", 32'(ram[0]), 0);
    chk("t3_ram31", 32'(ram[31]), 124);
    we0 = we_cnt;
    do_insert(8'h55, lat);
    chk("t3_full", 32'(Full), 1);
    chk("t3_full_lat", 32'(lat), 1);
    @(negedge CLOCK_50);
    chk("t3_full_we", 32'(we_cnt - we0), 0);
    chk("t3_full_count", 32'(Count), 32);
    chk("t3_full_loc", 32'(Loc), 0);

    // Test 4: Clear beats Start; Start while Busy is dropped
    d0 = done_cnt;
    @(negedge CLOCK_50);
    a = 8'h99; Start = 1'b1; Clear = 1'b1;
    @(negedge CLOCK_50);
    Start = 1'b0; Clear = 1'b0;
    chk("t4_busy", 32'(Busy), 0);
    chk("t4_count", 32'(Count), 0);
    chk("t4_full_hold", 32'(Full), 1);
    repeat (3) @(negedge CLOCK_50);
    chk("t4_nodone", 32'(done_cnt - d0), 0);
    d0 = done_cnt;
    a = 8'h55; Start = 1'b1;
    @(negedge CLOCK_50);
    a = 8'h77;
    @(negedge CLOCK_50);
    Start = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    chk("t4_one_done", 32'(done_cnt - d0), 1);
    chk("t4_count1", 32'(Count), 1);
    chk("t4_ram0", 32'(ram[0]), 32'h55);
    chk("t4_full_clr", 32'(Full), 0);

    // Test 5: reset in the middle of a shift
    @(negedge CLOCK_50);
    a = 8'h11; Start = 1'b1;
    @(negedge CLOCK_50);
    Start = 1'b0;
    lat = 0;
    while (!mem_we && lat < 20) begin
      @(negedge CLOCK_50);
      lat++;
    end
    chk("t5_reach_shift", 32'(mem_we), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_we_drop", 32'(mem_we), 0);
    chk("t5_busy", 32'(Busy), 0);
    chk("t5_count", 32'(Count), 0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    do_insert(8'h22, lat);
    chk("t5_loc", 32'(Loc), 0);
    chk("t5_count1", 32'(Count), 1);
    chk("t5_lat", 32'(lat), 2);

    // Test 6: random fill against a sorted-list model
    do_clear();
    q.delete();
    for (int i = 0; i < SIZE; i++) begin
      key = 8'($urandom_range(0, 255));
      pos = 0;
      foreach (q[k]) if (q[k] <= int'(key)) pos++;
      s = q.size() - pos;
      t = (pos > 0) ? 1 : 0;
      exp_lat = 3*s + 2*t + 2;
      q.insert(pos, int'(key));
      do_insert(key, lat);
      chk("t6_loc", 32'(Loc), 32'(pos));
      chk("t6_lat", 32'(lat), 32'(exp_lat));
    end
    chk("t6_count", 32'(Count), 32);
    for (int i = 0; i < SIZE; i++) chk("t6_ram", 32'(ram[i]), 32'(q[i]));
    found = 0;
    for (int i = 0; i < SIZE; i++) begin
      lo = 0; hi = SIZE - 1;
      while (lo <= hi) begin
        mid = (lo + hi) / 2;
        if (int'(ram[mid]) == q[i]) begin found++; break; end
        else if (int'(ram[mid]) < q[i]) lo = mid + 1;
        else hi = mid - 1;
      end
    end
    chk("t6_search", 32'(found), 32'(SIZE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
